// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: shared arbiter types and widths
// Provides the arbiter state encoding, master index constants, the starvation
// counter width and the memory bus widths used by rom_arbiter and its counter.
package rom_arbiter_pkg;
   localparam int MemAddrBus = 32;
   localparam int MemBus     = 32;
   localparam int STARVE_W   = 4;
   localparam int ARB_M0     = 0;
   localparam int ARB_M1     = 1;
   typedef enum logic {ARB_FREE = 1'b0, ARB_LOCK = 1'b1} arb_state_e;
endpackage

// File: rtl/rom_arb_starve_cnt.sv
// rom_arb_starve_cnt: saturating count of consecutive denied loader request cycles
// Ports: clk, rst (sync, active-high), req (loader requesting), gnt (loader granted),
//        starve_hit (count has reached STARVE_MAX).
module rom_arb_starve_cnt
   import rom_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic req,
   input  logic gnt,
   output logic starve_hit
);
   logic [STARVE_W-1:0] cnt;
   always_ff @(posedge clk)
      cnt <= (rst || !req || gnt) ? '0 : (&cnt ? cnt : cnt + 1'b1);
   assign starve_hit = cnt == STARVE_W'(STARVE_MAX);
endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares the single-port instruction ROM between fetch (m0) and loader (m1)
// Ports: clk, rst (sync, active-high);
//        m0_req_i/m0_addr_i -> m0_gnt_o, m0_rvalid_o, m0_rdata_o (fetch, read-only);
//        m1_req_i/m1_we_i/m1_lock_i/m1_addr_i/m1_wdata_i -> m1_gnt_o, m1_rvalid_o,
//        m1_rdata_o, m1_err_o (loader, read/write, lockable);
//        rom_we_o/rom_addr_o/rom_wdata_o to the ROM, rom_rdata_i from it (combinational).
// Macro ROM_ARB_WPROT_EN: blocks loader writes at or above PROT_BASE and flags m1_err_o.
module rom_arbiter
   import rom_arbiter_pkg::*;
#(
   parameter int                    STARVE_MAX = 8,
   parameter logic [MemAddrBus-1:0] PROT_BASE  = 32'h0000_1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_req_i,
   input  logic [MemAddrBus-1:0] m0_addr_i,
   output logic                  m0_gnt_o,
   output logic                  m0_rvalid_o,
   output logic [MemBus-1:0]     m0_rdata_o,
   input  logic                  m1_req_i,
   input  logic                  m1_we_i,
   input  logic                  m1_lock_i,
   input  logic [MemAddrBus-1:0] m1_addr_i,
   input  logic [MemBus-1:0]     m1_wdata_i,
   output logic                  m1_gnt_o,
   output logic                  m1_rvalid_o,
   output logic [MemBus-1:0]     m1_rdata_o,
   output logic                  m1_err_o,
   output logic                  rom_we_o,
   output logic [MemAddrBus-1:0] rom_addr_o,
   output logic [MemBus-1:0]     rom_wdata_o,
   input  logic [MemBus-1:0]     rom_rdata_i
);
`ifdef ROM_ARB_WPROT_EN
   localparam bit WPROT_EN = 1'b1;
`else
   localparam bit WPROT_EN = 1'b0;
`endif
   arb_state_e state, state_nxt;
   logic [1:0] gnt;
   logic       starve_hit, prot, rv0, rv1, err;
   rom_arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
      .clk        (clk),
      .rst        (rst),
      .req        (m1_req_i),
      .gnt        (gnt[ARB_M1]),
      .starve_hit (starve_hit)
   );
   // Grants are gated by rst so nothing reaches the ROM while in reset.
   always_comb begin
      gnt       = 2'b00;
      state_nxt = ARB_FREE;
      if (!rst && state == ARB_LOCK) begin
         gnt[ARB_M1] = m1_req_i;
         state_nxt   = (m1_req_i && m1_lock_i) ? ARB_LOCK : ARB_FREE;
      end else if (!rst) begin
         gnt[ARB_M1] = m1_req_i && (starve_hit || !m0_req_i);
         gnt[ARB_M0] = m0_req_i && !gnt[ARB_M1];
         state_nxt   = (gnt[ARB_M1] && m1_lock_i) ? ARB_LOCK : ARB_FREE;
      end
   end
   assign prot        = WPROT_EN && m1_we_i && (m1_addr_i >= PROT_BASE);
   assign m0_gnt_o    = gnt[ARB_M0];
   assign m1_gnt_o    = gnt[ARB_M1];
   assign rom_we_o    = gnt[ARB_M1] && m1_we_i && !prot;
   assign rom_addr_o  = gnt[ARB_M0] ? m0_addr_i : gnt[ARB_M1] ? m1_addr_i : '0;
   assign rom_wdata_o = gnt[ARB_M1] ? m1_wdata_i : '0;
   // Registered strobes are masked during rst so a pending response is dropped at once.
   assign m0_rvalid_o = rv0 && !rst;
   assign m1_rvalid_o = rv1 && !rst;
   assign m1_err_o    = err && !rst;
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ARB_FREE;
         rv0        <= 1'b0;
         rv1        <= 1'b0;
         err        <= 1'b0;
         m0_rdata_o <= '0;
         m1_rdata_o <= '0;
      end else begin
         state <= state_nxt;
         rv0   <= gnt[ARB_M0];
         rv1   <= gnt[ARB_M1] && !m1_we_i;
         err   <= gnt[ARB_M1] && prot;
         if (gnt[ARB_M0]) m0_rdata_o <= rom_rdata_i;
         if (gnt[ARB_M1] && !m1_we_i) m1_rdata_o <= rom_rdata_i;
      end
   end
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed bench with a behavioural arbiter/memory model and per-cycle compare
module tb_rom_arbiter;
   localparam int          STARVE_MAX = 8;
   localparam logic [31:0] PROT_BASE  = 32'h0000_1000;
`ifdef ROM_ARB_WPROT_EN
   localparam bit WP = 1'b1;
`else
   localparam bit WP = 1'b0;
`endif
   logic        clk = 1'b0, rst = 1'b1;
   logic        m0_req = 1'b1, m1_req = 1'b1, m1_we = 1'b1, m1_lock = 1'b0;
   logic [31:0] m0_addr = '0, m1_addr = '0, m1_wdata = 32'h55;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, m1_err, rom_we;
   logic [31:0] m0_rdata, m1_rdata, rom_addr, rom_wdata, rom_rdata;
   logic [31:0] rom_mem [0:2047];
   logic [31:0] exp_mem [0:2047];
   int          passed = 0, total = 0;

   always #5 clk = ~clk;

   rom_arbiter #(.STARVE_MAX(STARVE_MAX), .PROT_BASE(PROT_BASE)) dut (
      .clk(clk), .rst(rst),
      .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_gnt_o(m0_gnt),
      .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
      .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_lock_i(m1_lock),
      .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt),
      .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
      .rom_we_o(rom_we), .rom_addr_o(rom_addr), .rom_wdata_o(rom_wdata),
      .rom_rdata_i(rom_rdata)
   );

   // ROM peripheral: combinational read, write on posedge.
   assign rom_rdata = rom_mem[rom_addr[12:2]];
   always @(posedge clk) if (rom_we) rom_mem[rom_addr[12:2]] <= rom_wdata;

   initial begin
      for (int i = 0; i < 2048; i++) begin
         rom_mem[i] = 32'hA000_0000 + i;
         exp_mem[i] = 32'hA000_0000 + i;
      end
      rom_mem[4] = 32'hDEAD_BEEF;
      exp_mem[4] = 32'hDEAD_BEEF;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Model: ownership flag, consecutive wait count, response expectations, memory image.
   bit          locked = 0;
   int          waited = 0;
   bit          ev0 = 0, ev1 = 0, eerr = 0;
   logic [31:0] er0 = '0, er1 = '0;
   always @(negedge clk) begin
      bit e0, e1, prot, ewe;
      e0 = 0;
      e1 = 0;
      if (!rst && locked) e1 = m1_req;
      else if (!rst) begin
         e1 = m1_req && (waited == STARVE_MAX || !m0_req);
         e0 = m0_req && !e1;
      end
      prot = WP && m1_we && (m1_addr >= PROT_BASE);
      ewe  = e1 && m1_we && !prot;
      chk("m0_gnt", 32'(m0_gnt), 32'(e0));
      chk("m1_gnt", 32'(m1_gnt), 32'(e1));
      chk("rom_we", 32'(rom_we), 32'(ewe));
      chk("rom_addr", rom_addr, e0 ? m0_addr : e1 ? m1_addr : 32'h0);
      chk("rom_wdata", rom_wdata, e1 ? m1_wdata : 32'h0);
      chk("m0_rvalid", 32'(m0_rvalid), 32'(ev0 && !rst));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(ev1 && !rst));
      chk("m1_err", 32'(m1_err), 32'(eerr && !rst));
      chk("m0_rdata", m0_rdata, er0);
      chk("m1_rdata", m1_rdata, er1);
      ev0  = !rst && e0;
      ev1  = !rst && e1 && !m1_we;
      eerr = !rst && e1 && prot;
      if (rst) begin
         er0 = '0;
         er1 = '0;
      end else begin
         if (e0) er0 = exp_mem[m0_addr[12:2]];
         if (e1 && !m1_we) er1 = exp_mem[m1_addr[12:2]];
      end
      if (ewe) exp_mem[m1_addr[12:2]] = m1_wdata;
      waited = (!rst && m1_req && !e1) ? (waited < 15 ? waited + 1 : 15) : 0;
      locked = !rst && (locked ? (m1_req && m1_lock) : (e1 && m1_lock));
   end

   task automatic step(input logic r, input logic m0r, input logic [31:0] m0a,
                       input logic m1r, input logic we, input logic lk,
                       input logic [31:0] m1a, input logic [31:0] wd);
      @(posedge clk);
      #1;
      rst = r; m0_req = m0r; m0_addr = m0a;
      m1_req = m1r; m1_we = we; m1_lock = lk; m1_addr = m1a; m1_wdata = wd;
      @(negedge clk);
   endtask

   initial begin
      // Reset held with both masters requesting, m1 attempting a write.
      for (int i = 0; i < 3; i++) step(1, 1, 32'h0, 1, 1, 0, 32'h0, 32'h55);
      chk("rst_m0_gnt", 32'(m0_gnt), 32'h0);
      chk("rst_m1_gnt", 32'(m1_gnt), 32'h0);
      chk("rst_rom_we", 32'(rom_we), 32'h0);
      chk("rst_rvalid", 32'({m0_rvalid, m1_rvalid, m1_err}), 32'h0);
      step(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
      // Fetch read of word 4.
      step(0, 1, 32'h10, 0, 0, 0, 32'h0, 32'h0);
      chk("fetch_gnt", 32'(m0_gnt), 32'h1);
      step(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
      chk("fetch_rvalid", 32'(m0_rvalid), 32'h1);
      chk("fetch_rdata", m0_rdata, 32'hDEAD_BEEF);
      // Contention: m1 wins on the 9th cycle only.
      for (int i = 0; i < 12; i++) begin
         step(0, 1, 32'h40, 1, 0, 0, 32'h20, 32'h0);
         chk($sformatf("cont_m0_%0d", i), 32'(m0_gnt), (i == 8) ? 32'h0 : 32'h1);
         chk($sformatf("cont_m1_%0d", i), 32'(m1_gnt), (i == 8) ? 32'h1 : 32'h0);
      end
      step(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
      // Locked burst: four loader writes while fetch keeps requesting.
      for (int i = 0; i < 4; i++) begin
         step(0, i != 0, 32'h8, 1, 1, i != 3, 32'(i * 4), 32'(i + 1));
         chk($sformatf("burst_m1_%0d", i), 32'(m1_gnt), 32'h1);
         chk($sformatf("burst_m0_%0d", i), 32'(m0_gnt), 32'h0);
      end
      step(0, 1, 32'h8, 0, 0, 0, 32'h0, 32'h0);
      chk("burst_free", 32'(m0_gnt), 32'h1);
      step(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
      chk("burst_rdata", m0_rdata, 32'h3);
      // Loader write at the protection base, then read it back.
      step(0, 0, 32'h0, 1, 1, 0, 32'h1000, 32'hAA);
      chk("prot_gnt", 32'(m1_gnt), 32'h1);
      chk("prot_we", 32'(rom_we), WP ? 32'h0 : 32'h1);
      step(0, 0, 32'h0, 1, 0, 0, 32'h1000, 32'h0);
      chk("prot_err", 32'(m1_err), WP ? 32'h1 : 32'h0);
      step(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
      chk("prot_rdata", m1_rdata, WP ? 32'hA000_0400 : 32'hAA);
      // Reset during a lock with a read response pending.
      step(0, 0, 32'h0, 1, 0, 1, 32'h4, 32'h0);
      chk("lock_gnt", 32'(m1_gnt), 32'h1);
      step(1, 1, 32'h0, 1, 0, 1, 32'h4, 32'h0);
      chk("mid_rst_gnt", 32'(m1_gnt), 32'h0);
      chk("mid_rst_rvalid", 32'(m1_rvalid), 32'h0);
      step(0, 1, 32'h0, 1, 0, 0, 32'h4, 32'h0);
      chk("after_rst_m0", 32'(m0_gnt), 32'h1);
      chk("after_rst_m1", 32'(m1_gnt), 32'h0);
      chk("after_rst_rvalid", 32'(m1_rvalid), 32'h0);
      step(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
      step(0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter that shares the single-port instruction ROM between the core instruction-fetch port (m0, read-only) and the program loader/debug port (m1, read/write). It sits between the core/loader masters and the `rom` peripheral and drives its `we_i`, `addr_i` and `data_i`. It returns registered read data with a valid strobe. Fetch has fixed priority. m1 is protected from starvation and can lock the ROM for burst loads.

## Interface
- STARVE_MAX, default 8: consecutive denied m1 request cycles after which m1 is granted once.
- PROT_BASE, default 32'h0000_1000: lowest byte address blocked for m1 writes when `ROM_ARB_WPROT_EN` is defined.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- m0_req_i  in  1  fetch request.
- m0_addr_i  in  32  fetch byte address.
- m0_gnt_o  out  1  fetch granted this cycle.
- m0_rvalid_o  out  1  m0_rdata_o valid.
- m0_rdata_o  out  32  fetch read data.
- m1_req_i  in  1  loader request.
- m1_we_i  in  1  loader write (1) or read (0).
- m1_lock_i  in  1  hold ownership after this grant.
- m1_addr_i  in  32  loader byte address.
- m1_wdata_i  in  32  loader write data.
- m1_gnt_o  out  1  loader granted this cycle.
- m1_rvalid_o  out  1  m1_rdata_o valid (reads only).
- m1_rdata_o  out  32  loader read data.
- m1_err_o  out  1  one-cycle pulse: a write was blocked.
- rom_we_o  out  1  to ROM we_i.
- rom_addr_o  out  32  to ROM addr_i.
- rom_wdata_o  out  32  to ROM data_i.
- rom_rdata_i  in  32  from ROM data_o (combinational read).

## Operation
- States:
  - FREE: normal arbitration.
  - LOCK: m1 owns the ROM.
- FREE arbitration, evaluated combinationally each cycle:
  - If m1_req_i is high and starve_cnt == STARVE_MAX, grant m1.
  - Otherwise, if m0_req_i is high, grant m0.
  - Otherwise, if m1_req_i is high, grant m1.
  - Otherwise, no grant.
- Transitions:
  - FREE to LOCK when m1 is granted with m1_lock_i = 1.
  - LOCK: m1_gnt_o follows m1_req_i; m0_gnt_o = 0.
  - LOCK to FREE on any cycle where m1_req_i is high and m1_lock_i is low (that access is still granted), or when m1_req_i is low.
- starve_cnt, 4 bits, saturating:
  - Increments while m1_req_i is high and m1 is not granted.
  - Clears on any m1 grant or when m1_req_i is low.
- ROM muxing:
  - rom_addr_o and rom_wdata_o come from the granted master; they are 0 when there is no grant.
  - rom_we_o = m1 granted & m1_we_i (subject to Configuration).
- Read data:
  - rom_rdata_i is captured into the granted master's rdata register on the grant cycle.
  - The matching rvalid pulses the next cycle.
  - rdata holds its value until the next capture for that master.
- Simultaneous m0/m1 requests in FREE with starve_cnt < STARVE_MAX: m0 wins and starve_cnt increments.
- Reset mid-operation: state returns to FREE and all pending rvalid are dropped. A write granted in the same cycle as rst = 1 is suppressed (rom_we_o = 0 while rst).

## Timing
- Grant is combinational in the request cycle (cycle T).
- The ROM is accessed in cycle T.
- rvalid and rdata appear at T+1; read latency is 1.
- Writes commit at the posedge ending cycle T. A read of the same address in T+1 returns the new data.
- Throughput: 1 access per cycle.
- Reset values: m0_gnt_o, m1_gnt_o, rvalids, rdatas, m1_err_o, rom_we_o = 0; state = FREE; starve_cnt = 0.
- With continuous m0 requests and m1 waiting, m1 is granted on the (STARVE_MAX+1)th cycle of waiting.

## Configuration
- `ROM_ARB_WPROT_EN` defined:
  - An m1 write with m1_addr_i >= PROT_BASE is granted (handshake completes) but rom_we_o stays 0.
  - m1_err_o pulses high at T+1.
- Not defined:
  - All granted m1 writes are forwarded to the ROM.
  - m1_err_o is tied to 0.
  - PROT_BASE is unused.

## Structure
- Shared package/defines:
  - Arbiter state encodings (ARB_FREE, ARB_LOCK).
  - Master index constants (ARB_M0, ARB_M1).
  - Width of starve_cnt.
  - Reuse of the existing `MemAddrBus`/`MemBus` widths.
- One sub-module, `rom_arb_starve_cnt`: the saturating starvation counter with compare output `starve_hit`.

## Test plan
- Reset: hold rst for 3 cycles with both requests high -> no grants, rom_we_o = 0, all outputs 0.
- m0 read only: m0_req with addr 0x10 at T, ROM word[4] = 0xDEADBEEF -> m0_gnt at T; m0_rvalid = 1 and m0_rdata = 0xDEADBEEF at T+1.
- Contention: m0 and m1 requesting continuously, STARVE_MAX = 8 -> m0 granted for 8 cycles, m1 granted on cycle 9, then m0 resumes.
- Lock burst: m1 writes 0x1..0x4 to 0x0..0xC with lock = 1 on the first three and lock = 0 on the last, while m0 requests -> 4 consecutive m1 grants, m0_gnt = 0 throughout, FREE after; m0 read of 0x8 returns 0x3.
- Write protect (macro on): m1 write 0xAA to 0x1000 -> m1_gnt = 1, rom_we_o = 0, m1_err_o pulses at T+1; a subsequent read returns the old value.
- Reset mid-lock: assert rst during LOCK with m1_req high -> next cycle state is FREE and a pending m1_rvalid is not emitted.
